interrupt_stack_sequencer: RTL and testbench
============================================

INTERRUPT_STACK_SEQUENCER -- requirements
Module: interrupt_stack_sequencer

Interface
REQ-001 SHALL have parameter INT_VECTOR, default 32'h0000_0002, PC loaded on interrupt entry.
REQ-002 SHALL have ports (one per line: name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  intr  in  1  external interrupt request, level, sampled on clk
  call, ret, rti  in  1 each  decoded one-cycle strobes from decode stage
  pc_next  in  32  return address (PC+1) of the decoded instruction
  call_target  in  32  R[Rdst] for CALL
  flags_in  in  3  current {C,N,Z}
  mem_ack  in  1  stack memory accepted current request
  mem_rdata  in  16  stack read data, valid in mem_ack cycle
  mem_req, mem_we  out  1 each  stack request; write when mem_we=1
  mem_wdata  out  16  stack write data
  sp_dec, sp_inc  out  1 each  SP adjust, pulsed in mem_ack cycle of a push / pop
  stall  out  1  freeze fetch/decode
  pc_load  out  1  one-cycle PC load strobe
  pc_out  out  32  PC value for pc_load
  flags_load  out  1  one-cycle flag restore strobe
  flags_out  out  3  restored {C,N,Z}
  busy  out  1  sequencer not IDLE

Function
REQ-003 SHALL implement states IDLE, PUSH_H, PUSH_L, PUSH_F, POP_F, POP_L, POP_H, LOAD.
REQ-004 SHALL, in IDLE, select start by priority rti > ret > call > pending interrupt; undecoded strobes outside IDLE ignored.
REQ-005 SHALL set int_pending on intr=1 in any state and clear it only on entry to PUSH_H for an interrupt.
REQ-006 SHALL, on interrupt start, save ret_addr=pc_next, target=INT_VECTOR, save_flags=flags_in; on call start save ret_addr=pc_next, target=call_target.
REQ-007 SHALL sequence: interrupt PUSH_H->PUSH_L->PUSH_F->LOAD; call PUSH_H->PUSH_L->LOAD; rti POP_F->POP_L->POP_H->LOAD; ret POP_L->POP_H->LOAD.
REQ-008 SHALL drive mem_wdata = ret_addr[31:16] in PUSH_H, ret_addr[15:0] in PUSH_L, {13'b0,save_flags} in PUSH_F.
REQ-009 SHALL capture mem_rdata[2:0] in POP_F, mem_rdata into target[15:0] in POP_L, into target[31:16] in POP_H.
REQ-010 SHALL hold mem_req=1, mem_we and mem_wdata stable in every PUSH/POP state until mem_ack; advance state only in the mem_ack cycle.
REQ-011 SHALL pulse sp_dec (push) or sp_inc (pop) exactly in each mem_ack cycle; never both.
REQ-012 SHALL in LOAD assert pc_load=1, pc_out=target for one cycle, flags_load=1 only for rti, then return to IDLE.
REQ-013 SHALL drive stall=busy=1 in every state except IDLE; all outputs registered or decoded from state only.
REQ-014 SHALL with mem_ack tied high give: interrupt 4 cycles IDLE-exit to IDLE, call 3, rti 4, ret 3.
REQ-015 SHALL ignore mem_ack while mem_req=0.

Reset
REQ-016 SHALL on reset=0 asynchronously enter IDLE, clear int_pending, ret_addr, target, save_flags; all outputs 0.
REQ-017 SHALL abort any in-flight sequence on reset with no further mem_req, sp or load pulse.

Configuration
REQ-018 SHALL gate flag save/restore with macro INT_FLAGS_SAVE_EN: defined -> REQ-007 sequences as stated; undefined -> PUSH_F and POP_F never entered, rti behaves as ret, flags_load constant 0.

Verification
REQ-019 Interrupt, ack always 1, pc_next=32'h0001_2345, flags 3'b101 -> writes 16'h0001, 16'h2345, 16'h0005, 3 sp_dec, pc_load with pc_out=32'h0000_0002.
REQ-020 rti, mem_rdata 16'h0003/16'h00AA/16'h0007 in successive acks -> flags_out=3'b011, pc_out=32'h0007_00AA, flags_load=1, 3 sp_inc.
REQ-021 call with call_target=32'h0000_0100, mem_ack delayed 3 cycles per access -> mem_req/wdata stable while waiting, pc_load at 32'h0000_0100 after 8 busy cycles.
REQ-022 intr and ret same IDLE cycle -> ret completes first, interrupt sequence starts on next IDLE cycle.
REQ-023 reset low during PUSH_L -> immediate IDLE, mem_req=0, no pc_load; int_pending cleared.
REQ-024 INT_FLAGS_SAVE_EN undefined, interrupt then rti -> only 2 pushes and 2 pops, flags_load never 1.

Source files
------------

// File: rtl/interrupt_stack_sequencer.sv
// Interrupt / CALL / RET / RTI stack sequencer: pushes and pops return state over a 16-bit stack port.
// Flag save/restore on interrupt/rti is enabled by defining INT_FLAGS_SAVE_EN.
module interrupt_stack_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr,
  input  logic        call,
  input  logic        ret,
  input  logic        rti,
  input  logic [31:0] pc_next,
  input  logic [31:0] call_target,
  input  logic [2:0]  flags_in,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic        busy
);

`ifdef INT_FLAGS_SAVE_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PUSH_H = 3'd1;
  localparam logic [2:0] PUSH_L = 3'd2;
  localparam logic [2:0] PUSH_F = 3'd3;
  localparam logic [2:0] POP_F  = 3'd4;
  localparam logic [2:0] POP_L  = 3'd5;
  localparam logic [2:0] POP_H  = 3'd6;
  localparam logic [2:0] LOAD   = 3'd7;

  logic [2:0]  state;
  logic        int_pending;
  logic        is_int;
  logic        is_rti;
  logic [31:0] ret_addr;
  logic [31:0] target;
  logic [2:0]  save_flags;
  logic        in_push;
  logic        in_pop;
  logic        start_int;

  assign in_push   = (state == PUSH_H) || (state == PUSH_L) || (state == PUSH_F);
  assign in_pop    = (state == POP_F) || (state == POP_L) || (state == POP_H);
  assign start_int = (state == IDLE) && !rti && !ret && !call && int_pending;

  assign mem_req    = in_push || in_pop;
  assign mem_we     = in_push;
  // Ack only matters while a request is outstanding, so it is gated by state.
  assign sp_dec     = in_push && mem_ack;
  assign sp_inc     = in_pop && mem_ack;
  assign busy       = (state != IDLE);
  assign stall      = busy;
  assign pc_load    = (state == LOAD);
  assign pc_out     = pc_load ? target : 32'h0;
  assign flags_load = FLAGS_EN && pc_load && is_rti;
  assign flags_out  = flags_load ? save_flags : 3'b000;

  always_comb begin
    mem_wdata = 16'h0;
    case (state)
      PUSH_H:  mem_wdata = ret_addr[31:16];
      PUSH_L:  mem_wdata = ret_addr[15:0];
      PUSH_F:  mem_wdata = {13'b0, save_flags};
      default: mem_wdata = 16'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      int_pending <= 1'b0;
      is_int      <= 1'b0;
      is_rti      <= 1'b0;
      ret_addr    <= 32'h0;
      target      <= 32'h0;
      save_flags  <= 3'b000;
    end else begin
      // Taking the interrupt wins over a still-high request in the same cycle.
      if (start_int)
        int_pending <= 1'b0;
      else if (intr)
        int_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (rti) begin
            is_int <= 1'b0;
            is_rti <= FLAGS_EN;
            state  <= FLAGS_EN ? POP_F : POP_L;
          end else if (ret) begin
            is_int <= 1'b0;
            is_rti <= 1'b0;
            state  <= POP_L;
          end else if (call) begin
            is_int   <= 1'b0;
            is_rti   <= 1'b0;
            ret_addr <= pc_next;
            target   <= call_target;
            state    <= PUSH_H;
          end else if (int_pending) begin
            is_int     <= 1'b1;
            is_rti     <= 1'b0;
            ret_addr   <= pc_next;
            target     <= INT_VECTOR;
            save_flags <= flags_in;
            state      <= PUSH_H;
          end
        end
        PUSH_H: if (mem_ack) state <= PUSH_L;
        PUSH_L: if (mem_ack) state <= (is_int && FLAGS_EN) ? PUSH_F : LOAD;
        PUSH_F: if (mem_ack) state <= LOAD;
        POP_F: if (mem_ack) begin
          save_flags <= mem_rdata[2:0];
          state      <= POP_L;
        end
        POP_L: if (mem_ack) begin
          target[15:0] <= mem_rdata;
          state        <= POP_H;
        end
        POP_H: if (mem_ack) begin
          target[31:16] <= mem_rdata;
          state         <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_stack_sequencer.sv
// Bench for interrupt_stack_sequencer: cycle vector table, directed corner sequences,
// and a random call/interrupt/return mix checked against a frame-level stack model.
module tb_interrupt_stack_sequencer;

`ifdef INT_FLAGS_SAVE_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam logic [31:0] VEC = 32'h0000_0002;
  localparam int K_CALL = 0, K_INT = 1, K_RET = 2, K_RTI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        intr, call, ret, rti;
  logic [31:0] pc_next, call_target;
  logic [2:0]  flags_in;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, sp_dec, sp_inc, stall, pc_load, flags_load, busy;
  logic [15:0] mem_wdata;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  interrupt_stack_sequencer #(.INT_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .intr(intr), .call(call), .ret(ret), .rti(rti),
    .pc_next(pc_next), .call_target(call_target), .flags_in(flags_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .sp_dec(sp_dec), .sp_inc(sp_inc), .stall(stall),
    .pc_load(pc_load), .pc_out(pc_out), .flags_load(flags_load), .flags_out(flags_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [15:0] mem_q[$];
  logic [15:0] wr_q[$];
  int n_dec, n_inc, n_load, n_fload, busy_cyc, stab_err, both_err;
  logic [31:0] ld_pc;
  logic [2:0]  ld_fl;

  typedef struct {
    logic call, ret, rti, ack;
    logic [6:0] exp;  // {busy, stall, mem_req, mem_we, sp_dec, sp_inc, pc_load}
  } vec_t;
  vec_t vt[12];

  typedef struct {
    bit          is_int;
    logic [31:0] ra;
    logic [2:0]  fl;
  } frame_t;
  frame_t frames[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Plays the stack memory with d wait cycles per access until the sequencer goes idle.
  task automatic service(input int d);
    int wcnt;
    bit done;
    logic [15:0] wd0;
    logic we0;
    wcnt = 0; done = 0; wd0 = '0; we0 = 1'b0;
    n_dec = 0; n_inc = 0; n_load = 0; n_fload = 0; busy_cyc = 0; stab_err = 0; both_err = 0;
    ld_pc = '0; ld_fl = '0;
    wr_q.delete();
    for (int c = 0; c < 200; c++) begin
      if (!busy) begin done = 1; break; end
      busy_cyc++;
      if (mem_req) begin
        if (wcnt == 0) begin wd0 = mem_wdata; we0 = mem_we; end
        else if (mem_wdata !== wd0 || mem_we !== we0) stab_err++;
        if (wcnt >= d) begin
          mem_ack = 1'b1;
          if (!mem_we) mem_rdata = (mem_q.size() > 0) ? mem_q.pop_back() : 16'hDEAD;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else mem_ack = 1'b0;
      #1;
      if (sp_dec) n_dec++;
      if (sp_inc) n_inc++;
      if (sp_dec && sp_inc) both_err++;
      if (mem_ack && mem_req && mem_we) begin
        wr_q.push_back(mem_wdata);
        mem_q.push_back(mem_wdata);
      end
      if (pc_load) begin
        n_load++; ld_pc = pc_out; ld_fl = flags_out;
        if (flags_load) n_fload++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL service_timeout: busy still %0b after 200 cycles", busy);
    end
  endtask

  task automatic run_op(input int kind, input logic [31:0] pcn, input logic [31:0] tgt,
                        input logic [2:0] fl, input int d);
    if (kind == K_INT) begin
      intr = 1'b1;
      @(negedge clk);
      intr = 1'b0;
    end
    pc_next = pcn; call_target = tgt; flags_in = fl;
    call = (kind == K_CALL); ret = (kind == K_RET); rti = (kind == K_RTI);
    @(negedge clk);
    call = 1'b0; ret = 1'b0; rti = 1'b0;
    service(d);
  endtask

  task automatic check_words(input string name, input logic [31:0] ra, input bit with_fl,
                             input logic [2:0] fl);
    logic [15:0] exp_w[$];
    exp_w.push_back(ra[31:16]);
    exp_w.push_back(ra[15:0]);
    if (with_fl) exp_w.push_back({13'b0, fl});
    check({name, "_wcount"}, wr_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), wr_q[i], exp_w[i]);
  endtask

  initial begin
    logic [31:0] pcn, tgt;
    logic [2:0]  fl;
    int d, nw, idle_busy, idle_load;
    bit push, is_int;
    frame_t f;

    reset = 1'b0; intr = 0; call = 0; ret = 0; rti = 0;
    pc_next = '0; call_target = '0; flags_in = '0; mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {mem_req, mem_we, mem_wdata, sp_dec, sp_inc, stall, pc_load,
                            pc_out, flags_load, flags_out, busy}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Cycle vectors: call then ret with ack held high; ack outside a request and strobes
    // outside IDLE must have no effect.
    vt[0]  = '{0, 0, 0, 1, 7'b0000000};
    vt[1]  = '{1, 0, 0, 1, 7'b0000000};
    vt[2]  = '{0, 0, 0, 1, 7'b1111100};
    vt[3]  = '{0, 0, 0, 1, 7'b1111100};
    vt[4]  = '{0, 0, 0, 0, 7'b1100001};
    vt[5]  = '{0, 1, 0, 0, 7'b0000000};
    vt[6]  = '{0, 0, 0, 0, 7'b1110000};
    vt[7]  = '{0, 0, 0, 1, 7'b1110010};
    vt[8]  = '{0, 0, 0, 1, 7'b1110010};
    vt[9]  = '{1, 0, 0, 1, 7'b1100001};
    vt[10] = '{0, 0, 0, 1, 7'b0000000};
    vt[11] = '{0, 0, 0, 0, 7'b0000000};
    for (int i = 0; i < 12; i++) begin
      call = vt[i].call; ret = vt[i].ret; rti = vt[i].rti; mem_ack = vt[i].ack;
      #1;
      check($sformatf("vec%0d", i), {busy, stall, mem_req, mem_we, sp_dec, sp_inc, pc_load},
            vt[i].exp);
      @(negedge clk);
    end
    call = 0; ret = 0; rti = 0; mem_ack = 0;
    mem_q.delete();

    // Interrupt entry with zero-wait memory.
    run_op(K_INT, 32'h0001_2345, 32'h0, 3'b101, 0);
    check_words("int", 32'h0001_2345, FE, 3'b101);
    check("int_sp_dec", n_dec, FE ? 3 : 2);
    check("int_pc", {n_load, ld_pc}, {32'd1, VEC});
    check("int_busy", busy_cyc, FE ? 4 : 3);
    check("int_fload", n_fload, 0);

    // Return from that interrupt.
    run_op(K_RTI, 32'h0, 32'h0, 3'b000, 0);
    check("rti1_sp_inc", n_inc, FE ? 3 : 2);
    check("rti1_pc", ld_pc, 32'h0001_2345);
    check("rti1_fload", n_fload, FE ? 1 : 0);
    check("rti1_flags", ld_fl, FE ? 3'b101 : 3'b000);
    check("rti1_busy", busy_cyc, FE ? 4 : 3);

    // rti with preset stack contents; without flag save it pops only the top two words.
    mem_q = '{16'h0007, 16'h00AA, 16'h0003};
    run_op(K_RTI, 32'h0, 32'h0, 3'b000, 0);
    check("rti2_pc", ld_pc, FE ? 32'h0007_00AA : 32'h00AA_0003);
    check("rti2_flags", {n_fload, 29'd0, ld_fl}, FE ? {32'd1, 29'd0, 3'b011} : 64'h0);
    check("rti2_sp_inc", n_inc, FE ? 3 : 2);
    check("rti2_both", both_err, 0);
    mem_q.delete();

    // CALL with three wait cycles per access.
    run_op(K_CALL, 32'h0000_4321, 32'h0000_0100, 3'b000, 3);
    check("call_slow_busy", busy_cyc, 9);
    check("call_slow_pc", {n_load, ld_pc}, {32'd1, 32'h0000_0100});
    check("call_slow_stable", stab_err, 0);
    check_words("call_slow", 32'h0000_4321, 1'b0, 3'b000);
    mem_q.delete();

    // intr together with ret: ret runs first, interrupt follows from the next IDLE cycle.
    mem_q = '{16'h0003, 16'h0042};
    ret = 1'b1; intr = 1'b1;
    @(negedge clk);
    ret = 1'b0; intr = 1'b0;
    service(0);
    check("race_ret", {n_load, n_dec, ld_pc}, {32'd1, 32'd0, 32'h0003_0042});
    check("race_idle", busy, 1'b0);
    pc_next = 32'h0000_0777; flags_in = 3'b010;
    @(negedge clk);
    check("race_int_start", {busy, mem_we}, 2'b11);
    service(0);
    check("race_int_pc", ld_pc, VEC);
    check_words("race_int", 32'h0000_0777, FE, 3'b010);
    mem_q.delete();

    // Reset while PUSH_L waits, with an interrupt pending.
    pc_next = 32'h0000_5A5A; call_target = 32'h0000_0300; call = 1'b1;
    @(negedge clk);
    call = 1'b0; mem_ack = 1'b1; intr = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; intr = 1'b0;
    #1;
    check("rst_in_push_l", {mem_req, mem_we, mem_wdata}, {2'b11, 16'h5A5A});
    #2 reset = 1'b0;
    #1;
    check("rst_abort", {busy, mem_req, pc_load, sp_dec, sp_inc}, 5'b0);
    idle_busy = 0; idle_load = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || mem_req) idle_busy++;
      if (pc_load) idle_load++;
    end
    check("rst_pending_cleared", {idle_busy, idle_load}, 64'h0);
    mem_q.delete();

    // Random nested calls/interrupts and matching returns against a frame model.
    frames.delete();
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 2);
      pcn = $urandom; tgt = $urandom; fl = 3'($urandom_range(0, 7));
      push = (frames.size() == 0) || (frames.size() < 6 && $urandom_range(0, 1) == 1);
      if (push) begin
        is_int = ($urandom_range(0, 1) == 1);
        nw = (is_int && FE) ? 3 : 2;
        run_op(is_int ? K_INT : K_CALL, pcn, tgt, fl, d);
        frames.push_back('{is_int, pcn, fl});
        check_words($sformatf("rnd%0d", n), pcn, is_int && FE, fl);
        check($sformatf("rnd%0d_pc", n), {n_load, ld_pc}, {32'd1, is_int ? VEC : tgt});
        check($sformatf("rnd%0d_sp", n), {n_dec, n_inc}, {nw, 32'd0});
      end else begin
        f = frames.pop_back();
        nw = (f.is_int && FE) ? 3 : 2;
        run_op(f.is_int ? K_RTI : K_RET, pcn, tgt, fl, d);
        check($sformatf("rnd%0d_pc", n), {n_load, ld_pc}, {32'd1, f.ra});
        check($sformatf("rnd%0d_sp", n), {n_dec, n_inc, wr_q.size()}, {32'd0, nw, 32'd0});
        check($sformatf("rnd%0d_fl", n), {n_fload, 29'd0, ld_fl},
              (f.is_int && FE) ? {32'd1, 29'd0, f.fl} : 64'h0);
      end
      check($sformatf("rnd%0d_busy", n), {busy_cyc, stab_err + both_err},
            {nw * (d + 1) + 1, 32'd0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
